fft_frame_monitor: RTL and testbench
====================================

Name: fft_frame_monitor

Overview:
Synthesizable per-frame monitor for the multi-lane streaming FFT output. Sits after the bit-reversal stage. Tracks bin indices and measures input-to-output latency in enabled cycles. Reports the peak-magnitude bin and, optionally, frame energy. Generalises the fixed 2-lane, N=4096 capture to LANES samples per clock and N = 2^LGN.

Parameters:
OWIDTH, 19, bits per real/imag component (signed two's complement)
LGN, 12, log2 of FFT size N
LANES, 2, samples per clock; power of two, 1..16, LANES < N
LATW, 16, latency counter width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_clk_enable  in  1  global enable; all state frozen when low
i_in_sync  in  1  marks first input sample of an FFT input frame
i_sync  in  1  marks output beat carrying bins 0..LANES-1
i_data  in  LANES*2*OWIDTH  lane 0 in MSBs; per lane {real, imag}, real upper
o_busy  out  1  high while a frame is being captured
o_bin_base  out  LGN  bin index of lane 0 on current beat (0 when idle)
o_frame_done  out  1  one-cycle pulse: peak/energy results updated
o_peak_bin  out  LGN  bin of maximum magnitude in last completed frame
o_peak_mag  out  OWIDTH+1  magnitude of that bin, unsigned
o_latency  out  LATW  enabled cycles from i_in_sync to i_sync
o_lat_valid  out  1  o_latency holds a measurement
o_overrun  out  1  one-cycle pulse: i_sync arrived mid-frame
o_energy  out  OWIDTH+1+LGN  sum of magnitudes over last frame (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame discards the partial frame; no o_frame_done.
- Rising edges with i_clk_enable=0 change nothing. Pulses (o_frame_done, o_overrun) are raised only on enabled edges and cleared on the next enabled edge.
- Magnitude per lane: |re|+|im|, OWIDTH+1 bits unsigned. |-2^(OWIDTH-1)| = 2^(OWIDTH-1), no wrap.
- States: IDLE and CAPTURE.
  - IDLE + i_sync: bin_base=0, beat=0, peak seeded from this beat, next state CAPTURE.
  - CAPTURE: beat increments per enabled cycle; o_bin_base = beat*LANES.
- Last beat (beat = N/LANES-1):
  - Final peak/energy registered; o_frame_done pulses on the next enabled edge; return to IDLE.
  - If i_sync coincides with that next beat, it starts a new frame with no gap.
- i_sync in CAPTURE before the last beat: o_overrun pulses, partial frame discarded, capture restarts at bin 0 with this beat. o_peak_* keep previous values.
- Peak tie rule: strict greater-than. The lowest bin wins, both within a beat (lower lane first) and across beats.
- o_peak_bin/o_peak_mag/o_energy hold until the next o_frame_done.
- Latency:
  - On enabled i_in_sync: counter=0, armed, o_lat_valid=0.
  - Each enabled cycle while armed: counter increments, saturating at 2^LATW-1.
  - First i_sync while armed: o_latency=counter, o_lat_valid=1, disarm.
  - i_in_sync and i_sync on the same cycle give latency 0. Later syncs do not remeasure. A new i_in_sync re-arms.
- With LANES=1, o_bin_base = beat.

Optional Feature:
FFT_MON_ENERGY_EN
- Defined: o_energy accumulates the lane magnitude sum over all N bins of the frame. It updates with o_frame_done; overrun resets the accumulator.
- Undefined: the accumulator is not built and o_energy is tied to 0.

Test Plan:
- Impulse, LANES=2, N=4096: frame with bin0 real=2047, all else 0 → o_frame_done after 2048 beats; o_peak_bin=0, o_peak_mag=2047; o_energy=2047 if enabled.
- Tone: bins 2000 and 2096 both magnitude 1000, rest 0 → o_peak_bin=2000 (tie rule), o_peak_mag=1000.
- Latency: i_in_sync, then i_sync 150 enabled cycles later with 20 disabled cycles interleaved → o_latency=150, o_lat_valid=1; a second i_sync leaves it unchanged.
- Overrun: i_sync again at beat 1000 → o_overrun pulse, o_bin_base returns to 0, o_frame_done 2048 beats after the second sync only.
- Reset mid-frame at beat 500 → all outputs 0 immediately, no o_frame_done; the next frame captures normally.
- Saturation/extreme: LATW=4, 40 cycles to sync → o_latency=15. Bin with re=im=-2^18 → o_peak_mag=2^19.

Source files
------------

// File: rtl/fft_frame_monitor_if.sv
// Streaming FFT output beat: frame syncs plus LANES packed {real, imag} samples.
interface fft_mon_stream_if #(
   parameter int unsigned DW = 76
) ();
   logic          i_in_sync;
   logic          i_sync;
   logic [DW-1:0] i_data;

   modport master (output i_in_sync, output i_sync, output i_data);
   modport slave  (input  i_in_sync, input  i_sync, input  i_data);
endinterface

// File: rtl/fft_frame_monitor.sv
// Per-frame monitor for the multi-lane FFT output: bin tracking, peak bin, sync latency.
// Optional frame energy accumulator enabled by `define FFT_MON_ENERGY_EN.
module fft_frame_monitor #(
   parameter int unsigned OWIDTH = 19,
   parameter int unsigned LGN    = 12,
   parameter int unsigned LANES  = 2,
   parameter int unsigned LATW   = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_clk_enable,
   fft_mon_stream_if.slave         stream_i,
   output logic                    o_busy,
   output logic [LGN-1:0]          o_bin_base,
   output logic                    o_frame_done,
   output logic [LGN-1:0]          o_peak_bin,
   output logic [OWIDTH:0]         o_peak_mag,
   output logic [LATW-1:0]         o_latency,
   output logic                    o_lat_valid,
   output logic                    o_overrun,
   output logic [OWIDTH+LGN:0]     o_energy
);
   localparam int unsigned DW = LANES * 2 * OWIDTH;
   localparam int unsigned MW = OWIDTH + 1;
   localparam int unsigned N  = 32'd1 << LGN;
   localparam logic [LGN-1:0]  LANE_STEP = LGN'(LANES);
   localparam logic [LGN-1:0]  LAST_PREV = LGN'(N - 2 * LANES);
   localparam logic [LATW-1:0] LAT_MAX   = '1;

   typedef enum logic {S_IDLE, S_CAPTURE} state_e;

   state_e            state_q, state_d;
   logic [LGN-1:0]    bin_q, bin_d;
   logic [MW-1:0]     run_mag_q, run_mag_d;
   logic [LGN-1:0]    run_bin_q, run_bin_d;
   logic [LGN-1:0]    peak_bin_q, peak_bin_d;
   logic [MW-1:0]     peak_mag_q, peak_mag_d;
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;
   logic [LATW-1:0]   lat_cnt_q, lat_cnt_d;
   logic              armed_q, armed_d;
   logic [LATW-1:0]   lat_q, lat_d;
   logic              lat_valid_q, lat_valid_d;

   logic [MW-1:0]     beat_mag, lane_mag;
   logic [LGN-1:0]    beat_lane, base_in, cand_bin;
   logic [LATW-1:0]   cnt_inc;
   logic              take, last, seed;

   // |re| + |im| for one lane; lane 0 sits in the MSBs, real above imag
   function automatic logic [MW-1:0] lane_mag_f(input logic [DW-1:0] d, input int unsigned l);
      logic [MW-1:0] re_x;
      logic [MW-1:0] im_x;
      re_x = {d[(LANES-1-l)*2*OWIDTH + 2*OWIDTH - 1], d[(LANES-1-l)*2*OWIDTH + OWIDTH +: OWIDTH]};
      im_x = {d[(LANES-1-l)*2*OWIDTH + OWIDTH - 1],   d[(LANES-1-l)*2*OWIDTH +: OWIDTH]};
      if (re_x[MW-1]) re_x = ~re_x + 1'b1;
      if (im_x[MW-1]) im_x = ~im_x + 1'b1;
      return re_x + im_x;
   endfunction

   // Largest lane of the beat; strict compare keeps the lowest lane on ties
   always_comb begin : beat_eval
      beat_mag  = '0;
      beat_lane = '0;
      lane_mag  = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_mag = lane_mag_f(stream_i.i_data, l);
         if (lane_mag > beat_mag) begin
            beat_mag  = lane_mag;
            beat_lane = LGN'(l);
         end
      end
   end

   always_comb begin : next_state
      state_d    = state_q;
      bin_d      = bin_q;
      run_mag_d  = run_mag_q;
      run_bin_d  = run_bin_q;
      peak_bin_d = peak_bin_q;
      peak_mag_d = peak_mag_q;
      done_d     = 1'b0;
      ovr_d      = 1'b0;
      seed       = 1'b0;
      base_in    = bin_q + LANE_STEP;
      cand_bin   = base_in + beat_lane;
      take       = beat_mag > run_mag_q;
      last       = (bin_q == LAST_PREV);
      case (state_q)
         S_IDLE: begin
            if (stream_i.i_sync) begin
               seed    = 1'b1;
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (last) begin
               state_d    = S_IDLE;
               bin_d      = '0;
               done_d     = 1'b1;
               peak_bin_d = take ? cand_bin : run_bin_q;
               peak_mag_d = take ? beat_mag : run_mag_q;
            end else if (stream_i.i_sync) begin
               seed  = 1'b1;
               ovr_d = 1'b1;
            end else begin
               bin_d = base_in;
               if (take) begin
                  run_mag_d = beat_mag;
                  run_bin_d = cand_bin;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // First beat of a frame (fresh or after overrun) seeds the running peak
      if (seed) begin
         bin_d     = '0;
         run_mag_d = beat_mag;
         run_bin_d = beat_lane;
      end
   end

   always_comb begin : latency_next
      lat_cnt_d   = lat_cnt_q;
      armed_d     = armed_q;
      lat_d       = lat_q;
      lat_valid_d = lat_valid_q;
      cnt_inc     = (lat_cnt_q == LAT_MAX) ? lat_cnt_q : lat_cnt_q + 1'b1;
      if (stream_i.i_in_sync) begin
         lat_cnt_d   = '0;
         armed_d     = 1'b1;
         lat_valid_d = 1'b0;
         if (stream_i.i_sync) begin
            lat_d       = '0;
            lat_valid_d = 1'b1;
            armed_d     = 1'b0;
         end
      end else if (armed_q) begin
         lat_cnt_d = cnt_inc;
         if (stream_i.i_sync) begin
            lat_d       = cnt_inc;
            lat_valid_d = 1'b1;
            armed_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         bin_q       <= '0;
         run_mag_q   <= '0;
         run_bin_q   <= '0;
         peak_bin_q  <= '0;
         peak_mag_q  <= '0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
         lat_cnt_q   <= '0;
         armed_q     <= 1'b0;
         lat_q       <= '0;
         lat_valid_q <= 1'b0;
      end else if (i_clk_enable) begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         run_mag_q   <= run_mag_d;
         run_bin_q   <= run_bin_d;
         peak_bin_q  <= peak_bin_d;
         peak_mag_q  <= peak_mag_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
         lat_cnt_q   <= lat_cnt_d;
         armed_q     <= armed_d;
         lat_q       <= lat_d;
         lat_valid_q <= lat_valid_d;
      end
   end

`ifdef FFT_MON_ENERGY_EN
   localparam int unsigned EW = OWIDTH + 1 + LGN;
   logic [EW-1:0] beat_sum, acc_q, acc_d, energy_q, energy_d;

   always_comb begin : energy_next
      beat_sum = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         beat_sum = beat_sum + EW'(lane_mag_f(stream_i.i_data, l));
      end
      acc_d    = acc_q;
      energy_d = energy_q;
      if (seed) begin
         acc_d = beat_sum;
      end else if (state_q == S_CAPTURE) begin
         if (last) begin
            energy_d = acc_q + beat_sum;
            acc_d    = '0;
         end else begin
            acc_d = acc_q + beat_sum;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         acc_q    <= '0;
         energy_q <= '0;
      end else if (i_clk_enable) begin
         acc_q    <= acc_d;
         energy_q <= energy_d;
      end
   end

   assign o_energy = energy_q;
`else
   assign o_energy = '0;
`endif

   assign o_busy       = (state_q == S_CAPTURE);
   assign o_bin_base   = bin_q;
   assign o_frame_done = done_q;
   assign o_peak_bin   = peak_bin_q;
   assign o_peak_mag   = peak_mag_q;
   assign o_latency    = lat_q;
   assign o_lat_valid  = lat_valid_q;
   assign o_overrun    = ovr_q;
endmodule

// File: tb/tb_fft_frame_monitor.sv
// Randomized bench for fft_frame_monitor against a whole-frame reference model.
// A second instance with LGN=4, LATW=4 shares the stream to observe latency saturation.
module tb_fft_frame_monitor;
   localparam int unsigned OWIDTH = 19;
   localparam int unsigned LGN    = 12;
   localparam int unsigned LANES  = 2;
   localparam int unsigned LATW   = 16;
   localparam int unsigned N      = 4096;
   localparam int unsigned BEATS  = N / LANES;
   localparam int unsigned DW     = LANES * 2 * OWIDTH;
`ifdef FFT_MON_ENERGY_EN
   localparam bit ENERGY_ON = 1'b1;
`else
   localparam bit ENERGY_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic en;
   always #5 clk = ~clk;

   fft_mon_stream_if #(.DW(DW)) stream ();

   logic                 busy, frame_done, lat_valid, overrun;
   logic [LGN-1:0]       bin_base, peak_bin;
   logic [OWIDTH:0]      peak_mag;
   logic [LATW-1:0]      latency;
   logic [OWIDTH+LGN:0]  energy;

   logic                 d2_busy, d2_frame_done, d2_lat_valid, d2_overrun;
   logic [3:0]           d2_bin_base, d2_peak_bin;
   logic [OWIDTH:0]      d2_peak_mag;
   logic [3:0]           d2_latency;
   logic [OWIDTH+4:0]    d2_energy;

   fft_frame_monitor #(.OWIDTH(OWIDTH), .LGN(LGN), .LANES(LANES), .LATW(LATW)) dut (
      .i_clk(clk), .i_reset(rst), .i_clk_enable(en), .stream_i(stream),
      .o_busy(busy), .o_bin_base(bin_base), .o_frame_done(frame_done),
      .o_peak_bin(peak_bin), .o_peak_mag(peak_mag), .o_latency(latency),
      .o_lat_valid(lat_valid), .o_overrun(overrun), .o_energy(energy));

   fft_frame_monitor #(.OWIDTH(OWIDTH), .LGN(4), .LANES(LANES), .LATW(4)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_clk_enable(en), .stream_i(stream),
      .o_busy(d2_busy), .o_bin_base(d2_bin_base), .o_frame_done(d2_frame_done),
      .o_peak_bin(d2_peak_bin), .o_peak_mag(d2_peak_mag), .o_latency(d2_latency),
      .o_lat_valid(d2_lat_valid), .o_overrun(d2_overrun), .o_energy(d2_energy));

   int     n_cmp = 0;
   int     n_err = 0;
   int     re_a[N];
   int     im_a[N];
   longint exp_base, prev_bin, prev_mag, prev_en, exp_lat, exp_lat2;
   bit     exp_lv;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint iabs(input int v);
      return (v < 0) ? longint'(-v) : longint'(v);
   endfunction

   // Reference: first bin holding the maximum |re|+|im|, and the frame sum
   task automatic model(output longint pb, output longint pm, output longint pe);
      longint m;
      pb = 0; pm = -1; pe = 0;
      for (int i = 0; i < int'(N); i++) begin
         m  = iabs(re_a[i]) + iabs(im_a[i]);
         pe += m;
         if (m > pm) begin pm = m; pb = i; end
      end
   endtask

   task automatic fill(input int amp);
      for (int i = 0; i < int'(N); i++) begin
         re_a[i] = int'($urandom_range(0, 2 * amp)) - amp;
         im_a[i] = int'($urandom_range(0, 2 * amp)) - amp;
      end
   endtask

   task automatic clear();
      for (int i = 0; i < int'(N); i++) begin re_a[i] = 0; im_a[i] = 0; end
   endtask

   task automatic drive_beat(input int b, input bit s, input bit ins);
      en = 1'b1;
      stream.i_sync    = s;
      stream.i_in_sync = ins;
      for (int l = 0; l < int'(LANES); l++) begin
         stream.i_data[(int'(LANES)-1-l)*2*OWIDTH + OWIDTH +: OWIDTH] = OWIDTH'(re_a[b*LANES+l]);
         stream.i_data[(int'(LANES)-1-l)*2*OWIDTH +: OWIDTH]          = OWIDTH'(im_a[b*LANES+l]);
      end
   endtask

   // Disabled edge with garbage inputs; nothing may move
   task automatic dis_cycle();
      en = 1'b0;
      stream.i_data    = DW'({$urandom, $urandom, $urandom});
      stream.i_sync    = 1'($urandom);
      stream.i_in_sync = 1'($urandom);
      tick();
      chk("frozen_bin_base", 64'(bin_base), exp_base);
      chk("frozen_done", 64'(frame_done), 64'd0);
      en = 1'b1;
      stream.i_sync    = 1'b0;
      stream.i_in_sync = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_bin_base"}, 64'(bin_base), 64'd0);
      chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
      chk({tag, "_peak_bin"}, 64'(peak_bin), 64'd0);
      chk({tag, "_peak_mag"}, 64'(peak_mag), 64'd0);
      chk({tag, "_latency"}, 64'(latency), 64'd0);
      chk({tag, "_lat_valid"}, 64'(lat_valid), 64'd0);
      chk({tag, "_overrun"}, 64'(overrun), 64'd0);
      chk({tag, "_energy"}, 64'(energy), 64'd0);
      chk({tag, "_d2_latency"}, 64'(d2_latency), 64'd0);
   endtask

   // In-sync pulse, then k-1 idle enabled edges so the next sync lands k edges later
   task automatic lat_prelude(input int k);
      exp_base = 0;
      en = 1'b1;
      stream.i_in_sync = 1'b1;
      stream.i_sync    = 1'b0;
      tick();
      stream.i_in_sync = 1'b0;
      chk("lat_armed_valid", 64'(lat_valid), 64'd0);
      chk("lat_armed_valid2", 64'(d2_lat_valid), 64'd0);
      for (int i = 0; i < k - 1; i++) begin
         if (i < 140 && i % 7 == 0) dis_cycle();
         stream.i_data = DW'({$urandom, $urandom, $urandom});
         tick();
      end
      exp_lat  = (k > 65535) ? 65535 : k;
      exp_lat2 = (k > 15) ? 15 : k;
      exp_lv   = 1'b1;
   endtask

   task automatic run_frame(input int nb, input bit ins, input bit gaps, input bit exp_ovr);
      longint pb, pm, pe;
      bit full;
      full = (nb == int'(BEATS));
      pb = 0; pm = 0; pe = 0;
      if (full) model(pb, pm, pe);
      for (int b = 0; b < nb; b++) begin
         if (gaps) while ($urandom_range(0, 7) == 0) dis_cycle();
         drive_beat(b, b == 0, ins && b == 0);
         tick();
         if (b == 0) begin
            chk("overrun_first_beat", 64'(overrun), 64'(exp_ovr));
            chk("held_peak_bin", 64'(peak_bin), prev_bin);
            chk("held_peak_mag", 64'(peak_mag), prev_mag);
            chk("held_energy", 64'(energy), prev_en);
            chk("latency", 64'(latency), exp_lat);
            chk("lat_valid", 64'(lat_valid), 64'(exp_lv));
            chk("latency_sat", 64'(d2_latency), exp_lat2);
         end else begin
            chk("overrun_quiet", 64'(overrun), 64'd0);
         end
         if (full && b == nb - 1) begin
            exp_base = 0;
            prev_bin = pb;
            prev_mag = pm;
            prev_en  = ENERGY_ON ? pe : 0;
            chk("frame_done", 64'(frame_done), 64'd1);
            chk("done_busy", 64'(busy), 64'd0);
            chk("done_bin_base", 64'(bin_base), 64'd0);
            chk("peak_bin", 64'(peak_bin), prev_bin);
            chk("peak_mag", 64'(peak_mag), prev_mag);
            chk("energy", 64'(energy), prev_en);
         end else begin
            exp_base = b * LANES;
            chk("bin_base", 64'(bin_base), exp_base);
            chk("busy", 64'(busy), 64'd1);
            chk("frame_done_quiet", 64'(frame_done), 64'd0);
         end
      end
      stream.i_sync    = 1'b0;
      stream.i_in_sync = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      stream.i_sync    = 1'b0;
      stream.i_in_sync = 1'b0;
      stream.i_data    = '0;
      exp_base = 0; prev_bin = 0; prev_mag = 0; prev_en = 0;
      exp_lat = 0; exp_lat2 = 0; exp_lv = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      en  = 1'b1;
      tick();

      // Impulse frame, latency of 150 enabled edges with disabled edges mixed in
      clear();
      re_a[0] = 2047;
      lat_prelude(150);
      run_frame(BEATS, 1'b0, 1'b1, 1'b0);

      // Tied tone bins, back to back; second sync must not remeasure latency
      clear();
      re_a[2000] = 600; im_a[2000] = -400;
      re_a[2096] = -1000;
      run_frame(BEATS, 1'b0, 1'b0, 1'b0);

      // Most-negative components give the largest magnitude; later tie loses
      fill(100000);
      re_a[7] = -262144;    im_a[7] = -262144;
      re_a[4094] = -262144; im_a[4094] = -262144;
      run_frame(BEATS, 1'b0, 1'b0, 1'b0);

      // Tiny amplitudes force ties within and across beats
      repeat (3) tick();
      fill(2);
      run_frame(BEATS, 1'b0, 1'b1, 1'b0);

      // Overrun at beat 1000, then a complete frame
      fill(200000);
      run_frame(1000, 1'b0, 1'b0, 1'b0);
      fill(200000);
      run_frame(BEATS, 1'b0, 1'b0, 1'b1);

      // In-sync and sync on the same edge
      tick();
      exp_lat = 0; exp_lat2 = 0; exp_lv = 1'b1;
      fill(50000);
      run_frame(BEATS, 1'b1, 1'b1, 1'b0);

      // 40 edges: plain count in the wide counter, saturated in the 4-bit one
      fill(1000);
      lat_prelude(40);
      run_frame(BEATS, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset at beat 500 clears everything immediately
      fill(30000);
      run_frame(500, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("midreset");
      prev_bin = 0; prev_mag = 0; prev_en = 0;
      exp_lat = 0; exp_lat2 = 0; exp_lv = 1'b0; exp_base = 0;
      tick();
      rst = 1'b0;
      tick();
      fill(250000);
      run_frame(BEATS, 1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
